dmd_frame_loader: RTL
=====================

// Module: dmd_frame_loader
// PURPOSE
//  Controller between the UART byte receiver and the double-buffered DMD frame RAM.
//  Parses a byte command stream, then writes pixels into the back buffer (or clears it).
//  Swaps front/back on the next vSync rising edge, and returns an ACK/NAK byte to the UART transmitter.
//  The video generator reads the half of the RAM selected by front_sel.
// PARAMETERS
//  WIDTH      128   DMD columns
//  HEIGHT     32    DMD rows
//  PIX_W      8     bits per stored pixel
//  BRIGHT_RST 8'hFF brightness value after reset
// PORTS
//  clk        in   1       pixel-domain clock (all inputs synchronous to it)
//  rst_n      in   1       asynchronous active-low reset
//  rx_valid   in   1       received byte available
//  rx_data    in   8       received byte
//  rx_ready   out  1       loader accepts rx_data this cycle (transfer = rx_valid & rx_ready)
//  tx_valid   out  1       response byte pending
//  tx_data    out  8       response byte: 8'h06 ACK, 8'h15 NAK
//  tx_ready   in   1       transmitter accepts tx_data (transfer = tx_valid & tx_ready)
//  vsync      in   1       vertical sync from the timing generator (active high)
//  wr_en      out  1       frame RAM write strobe
//  wr_addr    out  AW      {back_sel, pixel index}; AW = $clog2(WIDTH*HEIGHT)+1
//  wr_data    out  PIX_W   pixel value (low PIX_W bits of received byte)
//  front_sel  out  1       buffer half currently displayed
//  brightness out  8       global brightness register
// BEHAVIOUR
//  Reset: state IDLE; rx_ready=1, tx_valid=0, tx_data=0, wr_en=0, wr_addr=0, wr_data=0, front_sel=0, brightness=BRIGHT_RST.
//  Reset mid-frame abandons the frame, with no swap and no response.
//  Protocol: sync 8'hA5, then command byte:
//   8'h01 LOAD: WIDTH*HEIGHT payload bytes, row-major.
//   8'h02 BRIGHT: 1 byte, copied to brightness the cycle after its transfer; then ACK.
//   8'h03 CLEAR: no payload.
//   Any other command byte -> NAK.
//  States:
//   IDLE   : non-A5 bytes are accepted and discarded; on A5 go to CMD.
//   CMD    : 01 -> LOAD (index=0); 02 -> BRIGHT; 03 -> CLEAR (index=0); other -> RESP with NAK.
//   LOAD   : each transfer writes wr_en=1, wr_addr={~front_sel,index}, registered (1-cycle latency); index++.
//            After the last pixel (index=WIDTH*HEIGHT-1) go to SWAP (or CKSUM when DMD_CHECKSUM_EN is defined).
//   CLEAR  : rx_ready=0; writes 0 to one address per cycle for WIDTH*HEIGHT cycles, then SWAP.
//   SWAP   : rx_ready=0; waits for a vsync rising edge (vsync & ~vsync_q); front_sel toggles on that cycle; then RESP with ACK.
//   RESP   : rx_ready=0, tx_valid=1 held with tx_data stable until tx_ready; then IDLE.
//  A vsync edge in the same cycle SWAP is entered is not used; the first edge detected while in SWAP is used.
//  front_sel changes only in SWAP; the written half always equals ~front_sel at write time.
//  An A5 byte inside a payload is treated as data (no resync).
//  rx_ready=1 in IDLE, CMD, LOAD and BRIGHT only.
// CONFIGURATION
//  DMD_CHECKSUM_EN defined:
//   - LOAD is followed by state CKSUM, which accepts one byte.
//   - If it equals the XOR of all payload bytes -> SWAP then ACK.
//   - On mismatch: no swap, front_sel unchanged, RESP with NAK.
//  DMD_CHECKSUM_EN undefined: no CKSUM state; LOAD goes directly to SWAP; no extra byte is consumed.
// TESTING  (bench uses WIDTH=4, HEIGHT=2, PIX_W=8)
//  Reset -> front_sel=0, brightness=FF, tx_valid=0, rx_ready=1.
//  A5 01 then 8 bytes 10..17, vsync pulse -> writes addr 8..15 with data 10..17; front_sel=1 on the edge; tx 06.
//  A5 02 40 -> brightness=40, tx 06, front_sel unchanged.
//  A5 03, vsync -> 8 consecutive writes of 0 to the back half (addr 0..7 if front_sel=1); front_sel toggles; tx 06.
//  A5 7E -> tx 15, no writes; with tx_ready low 5 cycles, tx_data held and rx_ready=0 throughout.
//  rst_n low after 3 payload bytes -> no further writes; front_sel=0; next A5 01 restarts at index 0.
//  DMD_CHECKSUM_EN: payload 01..08, checksum 08 -> tx 06 with swap; checksum 00 -> tx 15 with no swap.

Source files
------------

// File: rtl/dmd_frame_loader_if.sv
// dmd_frame_loader_if
// Bundles the loader's byte streams, frame-RAM write port and display controls.
//   rx_valid/rx_data/rx_ready : received command bytes (UART receiver -> loader)
//   tx_valid/tx_data/tx_ready : response bytes (loader -> UART transmitter)
//   vsync                     : vertical sync from the timing generator
//   wr_en/wr_addr/wr_data     : frame RAM write port, wr_addr = {half, pixel index}
//   front_sel/brightness      : display controls for the video generator
// master = loader side, slave = surrounding system.
interface dmd_frame_loader_if #(
  parameter int AW    = 13,
  parameter int PIX_W = 8
);
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             rx_ready;
  logic             tx_valid;
  logic [7:0]       tx_data;
  logic             tx_ready;
  logic             vsync;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [PIX_W-1:0] wr_data;
  logic             front_sel;
  logic [7:0]       brightness;

  modport master (
    input  rx_valid, rx_data, tx_ready, vsync,
    output rx_ready, tx_valid, tx_data, wr_en, wr_addr, wr_data, front_sel, brightness
  );

  modport slave (
    output rx_valid, rx_data, tx_ready, vsync,
    input  rx_ready, tx_valid, tx_data, wr_en, wr_addr, wr_data, front_sel, brightness
  );
endinterface

// File: rtl/dmd_frame_loader.sv
// dmd_frame_loader
// Parses the UART command stream (A5 sync + command), loads or clears the back
// half of the double-buffered DMD frame RAM, swaps halves on the next vsync
// rising edge and answers with ACK (06) or NAK (15).
// Ports:
//   clk   : pixel-domain clock
//   rst_n : asynchronous active-low reset
//   bus   : dmd_frame_loader_if.master (byte streams, RAM write port, display controls)
// Optional feature macro: DMD_CHECKSUM_EN adds a trailing XOR checksum byte to LOAD.
//
// state  | meaning
// IDLE   | discard bytes until sync A5
// CMD    | decode command byte
// LOAD   | store WIDTH*HEIGHT payload bytes into the back half
// BRIGHT | take one brightness byte
// CLEAR  | write zeros over the back half, one pixel per cycle
// SWAP   | wait for vsync rising edge, then toggle front_sel
// RESP   | hold response byte until the transmitter takes it
// CKSUM  | (DMD_CHECKSUM_EN only) compare trailing byte with payload XOR
module dmd_frame_loader #(
  parameter int         WIDTH      = 128,
  parameter int         HEIGHT     = 32,
  parameter int         PIX_W      = 8,
  parameter logic [7:0] BRIGHT_RST = 8'hFF
) (
  input logic                clk,
  input logic                rst_n,
  dmd_frame_loader_if.master bus
);
  localparam int NPIX = WIDTH * HEIGHT;
  localparam int IW   = $clog2(NPIX);
  localparam int AW   = IW + 1;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NAK  = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_LOAD,
    S_BRIGHT,
    S_CLEAR,
    S_SWAP,
`ifdef DMD_CHECKSUM_EN
    S_CKSUM,
`endif
    S_RESP
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             wr_en_q, wr_en_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic [PIX_W-1:0] wr_data_q, wr_data_d;
  logic             front_q, front_d;
  logic [7:0]       bright_q, bright_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             vsync_q;
`ifdef DMD_CHECKSUM_EN
  logic [7:0]       cksum_q, cksum_d;
`endif

  logic rx_ready;
  logic rx_fire;
  logic last_pix;
  logic vs_edge;

  always_comb begin
    rx_ready = 1'b0;
    case (state_q)
      S_IDLE, S_CMD, S_LOAD, S_BRIGHT: rx_ready = 1'b1;
`ifdef DMD_CHECKSUM_EN
      S_CKSUM:                         rx_ready = 1'b1;
`endif
      default:                         rx_ready = 1'b0;
    endcase
  end

  assign rx_fire  = bus.rx_valid & rx_ready;
  assign last_pix = (idx_q == IW'(NPIX - 1));
  assign vs_edge  = bus.vsync & ~vsync_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    front_d   = front_q;
    bright_d  = bright_q;
    tx_data_d = tx_data_q;
`ifdef DMD_CHECKSUM_EN
    cksum_d   = cksum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (rx_fire && bus.rx_data == SYNC) state_d = S_CMD;
      end
      S_CMD: begin
        if (rx_fire) begin
          case (bus.rx_data)
            8'h01: begin
              state_d = S_LOAD;
              idx_d   = '0;
`ifdef DMD_CHECKSUM_EN
              cksum_d = '0;
`endif
            end
            8'h02: state_d = S_BRIGHT;
            8'h03: begin
              state_d = S_CLEAR;
              idx_d   = '0;
            end
            default: begin
              state_d   = S_RESP;
              tx_data_d = NAK;
            end
          endcase
        end
      end
      S_LOAD: begin
        if (rx_fire) begin
          wr_en_d   = 1'b1;
          wr_addr_d = {~front_q, idx_q};
          wr_data_d = bus.rx_data[PIX_W-1:0];
          idx_d     = idx_q + IW'(1);
`ifdef DMD_CHECKSUM_EN
          cksum_d   = cksum_q ^ bus.rx_data;
          if (last_pix) state_d = S_CKSUM;
`else
          if (last_pix) state_d = S_SWAP;
`endif
        end
      end
      S_BRIGHT: begin
        if (rx_fire) begin
          bright_d  = bus.rx_data;
          tx_data_d = ACK;
          state_d   = S_RESP;
        end
      end
      S_CLEAR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = {~front_q, idx_q};
        wr_data_d = '0;
        idx_d     = idx_q + IW'(1);
        if (last_pix) state_d = S_SWAP;
      end
      S_SWAP: begin
        if (vs_edge) begin
          front_d   = ~front_q;
          tx_data_d = ACK;
          state_d   = S_RESP;
        end
      end
`ifdef DMD_CHECKSUM_EN
      S_CKSUM: begin
        if (rx_fire) begin
          if (bus.rx_data == cksum_q) begin
            state_d = S_SWAP;
          end else begin
            tx_data_d = NAK;
            state_d   = S_RESP;
          end
        end
      end
`endif
      S_RESP: begin
        if (bus.tx_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      front_q   <= 1'b0;
      bright_q  <= BRIGHT_RST;
      tx_data_q <= '0;
      vsync_q   <= 1'b0;
`ifdef DMD_CHECKSUM_EN
      cksum_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      front_q   <= front_d;
      bright_q  <= bright_d;
      tx_data_q <= tx_data_d;
      vsync_q   <= bus.vsync;
`ifdef DMD_CHECKSUM_EN
      cksum_q   <= cksum_d;
`endif
    end
  end

  assign bus.rx_ready   = rx_ready;
  assign bus.tx_valid   = (state_q == S_RESP);
  assign bus.tx_data    = tx_data_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.front_sel  = front_q;
  assign bus.brightness = bright_q;
endmodule
